// File: rtl/cam_i2c_write_master.sv
// cam_i2c_write_master: serialises one camera register write (8-bit register
// address + 16-bit data) as a standard-mode I2C write transaction on
// open-drain SCL/SDA, reporting completion and NACK errors.
module cam_i2c_write_master #(
  parameter logic [6:0]  DEV_ADDR = 7'h3C,
  parameter int unsigned CLK_DIV  = 125
) (
  input  logic        sysClk,
  input  logic        rst_n,
  input  logic [7:0]  cam_i2c_addr,
  input  logic [15:0] cam_i2c_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic        busy,
  output logic        done,
  output logic        nack,
  output logic        ack_error,
  input  logic        err_clr
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_STOP,
    ST_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] qcnt, qcnt_n;
  logic [1:0]       qidx, qidx_n;
  logic [3:0]       bit_idx, bit_n;
  logic [1:0]       byte_idx, byte_n;
  logic [31:0]      shreg, sh_n;
  logic             nack_flag, flag_n;
  logic             sample_nack;
  logic             tick;
  logic             scl_n, sda_n;

  assign tick = (qcnt == CNT_W'(CLK_DIV - 1));

  // State, counters and registered bus/handshake outputs.
  // Outputs are decoded from the next-state values so that they stay aligned
  // with the state they describe while still coming straight from flops.
  always_ff @(posedge sysClk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      qcnt      <= '0;
      qidx      <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      nack_flag <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      ack_error <= 1'b0;
    end else begin
      state     <= state_n;
      qcnt      <= qcnt_n;
      qidx      <= qidx_n;
      bit_idx   <= bit_n;
      byte_idx  <= byte_n;
      shreg     <= sh_n;
      nack_flag <= flag_n;
      cmd_ready <= (state_n == ST_IDLE);
      busy      <= (state_n != ST_IDLE);
      done      <= (state_n == ST_DONE);
      nack      <= (state_n == ST_DONE) && flag_n;
      scl_oe    <= scl_n;
      sda_oe    <= sda_n;
      if (sample_nack)
        ack_error <= 1'b1;
      else if (err_clr)
        ack_error <= 1'b0;
    end
  end

  // Next-state, sequencing counters and bus drive decode.
  always_comb begin
    state_n     = state;
    qcnt_n      = '0;
    qidx_n      = qidx;
    bit_n       = bit_idx;
    byte_n      = byte_idx;
    sh_n        = shreg;
    flag_n      = nack_flag;
    sample_nack = 1'b0;

    case (state)
      ST_IDLE: begin
        qidx_n = '0;
        bit_n  = '0;
        byte_n = '0;
        if (cmd_valid) begin
          state_n = ST_START;
          sh_n    = {DEV_ADDR, 1'b0, cam_i2c_addr, cam_i2c_data};
          flag_n  = 1'b0;
        end
      end
      ST_START: begin
        qcnt_n = tick ? '0 : qcnt + CNT_W'(1);
        if (tick) begin
          qidx_n = qidx + 2'd1;
          if (qidx == 2'd3)
            state_n = ST_BYTE;
        end
      end
      ST_BYTE: begin
        qcnt_n = tick ? '0 : qcnt + CNT_W'(1);
        if (tick) begin
          qidx_n = qidx + 2'd1;
          // ACK slot: sample on the last cycle of q2
          if (bit_idx == 4'd8 && qidx == 2'd2 && sda_in) begin
            flag_n      = 1'b1;
            sample_nack = 1'b1;
          end
          if (qidx == 2'd3) begin
            if (bit_idx != 4'd8) begin
              sh_n  = {shreg[30:0], 1'b0};
              bit_n = bit_idx + 4'd1;
            end else begin
              bit_n = '0;
              if (nack_flag || byte_idx == 2'd3)
                state_n = ST_STOP;
              else
                byte_n = byte_idx + 2'd1;
            end
          end
        end
      end
      ST_STOP: begin
        qcnt_n = tick ? '0 : qcnt + CNT_W'(1);
        if (tick) begin
          qidx_n = qidx + 2'd1;
          if (qidx == 2'd3)
            state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        byte_n  = '0;
      end
      default: state_n = ST_IDLE;
    endcase

    scl_n = 1'b0;
    sda_n = 1'b0;
    case (state_n)
      ST_START: begin
        scl_n = (qidx_n == 2'd3);
        sda_n = (qidx_n != 2'd0);
      end
      ST_BYTE: begin
        scl_n = (qidx_n == 2'd0) || (qidx_n == 2'd3);
        sda_n = (bit_n != 4'd8) && !sh_n[31];
      end
      ST_STOP: begin
        scl_n = (qidx_n == 2'd0);
        sda_n = (qidx_n != 2'd3);
      end
      default: begin
        scl_n = 1'b0;
        sda_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cam_i2c_write_master.sv
// tb_cam_i2c_write_master: directed bench with a sampled I2C slave model.
module tb_cam_i2c_write_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        valid;
  logic        err_clr;
  logic        cmd_ready, scl_oe, sda_oe, busy, done, nack, ack_error;
  logic        sda_in;

  logic        scl_line, sda_line;
  logic        pull = 1'b0;

  int          nchecks = 0;
  int          nerrors = 0;
  int          cyc = 0;

  assign scl_line = ~scl_oe;
  assign sda_line = ~(sda_oe | pull);
  assign sda_in   = sda_line;

  cam_i2c_write_master #(.DEV_ADDR(7'h3C), .CLK_DIV(4)) dut (
    .sysClk       (clk),
    .rst_n        (rst_n),
    .cam_i2c_addr (addr),
    .cam_i2c_data (data),
    .cmd_valid    (valid),
    .cmd_ready    (cmd_ready),
    .sda_in       (sda_in),
    .scl_oe       (scl_oe),
    .sda_oe       (sda_oe),
    .busy         (busy),
    .done         (done),
    .nack         (nack),
    .ack_error    (ack_error),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: samples the bus once per system clock, decodes bytes,
  // counts START/STOP conditions and ACKs every byte except nack_byte.
  logic       ps = 1'b1;
  logic       psd = 1'b1;
  logic [7:0] sh = '0;
  logic [7:0] rx [4];
  int         bitcnt = 0;
  int         nbytes = 0;
  int         nstart = 0;
  int         nstop = 0;
  int         nack_byte = 99;

  always @(negedge clk) begin
    ps  <= scl_line;
    psd <= sda_line;
    if (ps && scl_line && psd && !sda_line) begin
      nstart <= nstart + 1;
      bitcnt <= 0;
      nbytes <= 0;
    end else if (ps && scl_line && !psd && sda_line) begin
      nstop <= nstop + 1;
    end else if (!ps && scl_line) begin
      if (bitcnt < 8) begin
        sh     <= {sh[6:0], sda_line};
        bitcnt <= bitcnt + 1;
      end else begin
        if (nbytes < 4) rx[nbytes[1:0]] <= sh;
        nbytes <= nbytes + 1;
        bitcnt <= 0;
      end
    end else if (ps && !scl_line) begin
      pull <= (bitcnt == 8) && (nbytes != nack_byte);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [15:0] d, output int acc);
    @(negedge clk);
    addr  = a;
    data  = d;
    valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    check("accept_ready", 32'(cmd_ready), 0);
    check("accept_busy", 32'(busy), 1);
    valid = 1'b0;
  endtask

  task automatic wait_done(output int dc, output logic nk);
    dc = -1;
    nk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        nk = nack;
        break;
      end
    end
    if (dc < 0) check("done_timeout", 0, 1);
  endtask

  task automatic check_bytes(input int n, input logic [31:0] exp);
    check("rx_count", nbytes, n);
    for (int i = 0; i < n; i++)
      check("rx_byte", 32'(rx[i]), 32'(exp[31-8*i -: 8]));
  endtask

  int   acc, dc, d1, a2, s0, p0;
  logic nk;

  initial begin
    rst_n = 1'b0; valid = 1'b0; err_clr = 1'b0; addr = '0; data = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_scl_oe", 32'(scl_oe), 0);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_nack", 32'(nack), 0);
    check("rst_ack_error", 32'(ack_error), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal write; a cmd_valid pulse while busy must be ignored
    s0 = nstart; p0 = nstop;
    send(8'h35, 16'hABCD, acc);
    while (cyc < acc + 100) @(negedge clk);
    addr = 8'h77; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_done(dc, nk);
    check("t1_latency", dc - acc, 608);
    check("t1_nack", 32'(nk), 0);
    check("t1_ack_error", 32'(ack_error), 0);
    check_bytes(4, 32'h7835ABCD);
    check("t1_starts", nstart - s0, 1);
    check("t1_stops", nstop - p0, 1);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 0);
    check("t1_ready_after", 32'(cmd_ready), 1);
    repeat (5) @(negedge clk);
    check("t1_no_ghost_cmd", 32'(busy), 0);

    // NACK on byte 1, err_clr coincident with the NACK sample
    nack_byte = 1;
    s0 = nstart; p0 = nstop;
    send(8'h35, 16'hABCD, acc);
    while (cyc < acc + 299) @(negedge clk);
    check("t2_ack_err_pre", 32'(ack_error), 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t2_set_wins", 32'(ack_error), 1);
    wait_done(dc, nk);
    check("t2_latency", dc - acc, 320);
    check("t2_nack", 32'(nk), 1);
    check_bytes(2, 32'h78350000);
    check("t2_starts", nstart - s0, 1);
    check("t2_stops", nstop - p0, 1);
    repeat (10) @(negedge clk);
    check("t2_sticky", 32'(ack_error), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t2_cleared", 32'(ack_error), 0);
    nack_byte = 99;

    // Back-to-back with cmd_valid held
    s0 = nstart; p0 = nstop;
    @(negedge clk);
    addr = 8'h12; data = 16'h0001; valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    addr = 8'h13; data = 16'h0002;
    wait_done(d1, nk);
    check("t3_latency1", d1 - acc, 608);
    check_bytes(4, 32'h78120001);
    a2 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin
        a2 = cyc;
        break;
      end
    end
    valid = 1'b0;
    check("t3_gap", a2 - d1, 2);
    wait_done(dc, nk);
    check("t3_latency2", dc - a2, 608);
    check_bytes(4, 32'h78130002);
    check("t3_starts", nstart - s0, 2);
    check("t3_stops", nstop - p0, 2);

    // Reset mid-way through byte 2, then a clean write
    send(8'h35, 16'hABCD, acc);
    dc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (nbytes == 2 && bitcnt == 3) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) check("t4_reach_byte2", 0, 1);
    rst_n = 1'b0;
    #1;
    check("t4_scl_released", 32'(scl_oe), 0);
    check("t4_sda_released", 32'(sda_oe), 0);
    check("t4_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_ready", 32'(cmd_ready), 1);
    check("t4_ack_error", 32'(ack_error), 0);
    s0 = nstart; p0 = nstop;
    send(8'h35, 16'hABCD, acc);
    wait_done(dc, nk);
    check("t4_latency", dc - acc, 608);
    check("t4_nack", 32'(nk), 0);
    check_bytes(4, 32'h7835ABCD);
    check("t4_stops", nstop - p0, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
